// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU memory port between the CPU (master) and mem_ctrl (slave).
//   addr[29:0]   word address, held stable from request until mem_ready
//   re           read request
//   we[3:0]      byte-lane write enables, bit i -> wdata[8i+7:8i]; any bit set = write
//   wdata[31:0]  write data, held stable from request until mem_ready
//   rdata[31:0]  read data, valid only while mem_ready is high
//   mem_ready    one-cycle completion pulse
interface mem_ctrl_if;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;

  modport master (output addr, re, we, wdata, input rdata, mem_ready);
  modport slave  (input addr, re, we, wdata, output rdata, mem_ready);
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single bus slave behind the CPU memory port. Services one
// word-addressed read or byte-masked write at a time from an internal
// single-port RAM or a small MMIO region, after WAIT_STATES busy cycles,
// and answers with a one-cycle mem_ready pulse.
//
// Parameters:
//   RAM_WORDS    RAM depth in 32-bit words (power of two, >= 16)
//   WAIT_STATES  extra busy cycles per access (0..15)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   bus          mem_ctrl_if slave modport (addr/re/we/wdata in, rdata/mem_ready out)
//   led[7:0]     MMIO output register
// Address map (addr[29] selects RAM vs MMIO):
//   addr[29]=0     RAM, index addr[log2(RAM_WORDS)-1:0], upper bits alias
//   30'h2000_0000  LED register (write via we[0], read {24'b0, led})
//   30'h2000_0001  free-running cycle counter, read-only
//   other MMIO     reads 0, writes ignored
// Build option:
//   MEM_CTRL_TIMER_EN  defined -> cycle counter present; undefined -> the
//                      counter address reads 0 with unchanged latency.
module mem_ctrl #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus,
  output logic [7:0] led
);

  localparam int unsigned AW  = $clog2(RAM_WORDS);
  localparam int unsigned WCW = 4;
  localparam int unsigned DW  = 32;

  localparam logic [29:0] LED_ADDR = 30'h2000_0000;
  localparam logic [29:0] CNT_ADDR = 30'h2000_0001;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Request captured in IDLE and held for the whole transaction.
  typedef struct packed {
    logic [29:0]   addr;
    logic [3:0]    we;
    logic [DW-1:0] wdata;
    logic          is_wr;
  } req_t;

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  req_t           req_q, req_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           mem_ready_q, mem_ready_d;
  logic [7:0]     led_q, led_d;

  logic [DW-1:0]  cnt_val_c;
  logic           access_c;
  logic           ram_sel_c;
  logic           led_sel_c;
  logic           cnt_sel_c;
  logic           ram_we_c;
  logic [AW-1:0]  ram_idx_c;

  logic [DW-1:0]  mem [RAM_WORDS];

  // Cycle counter: cleared by reset, free-running and wrapping afterwards.
`ifdef MEM_CTRL_TIMER_EN
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_val_c = cnt_q;
`else
  assign cnt_val_c = '0;
`endif

  // Address decode of the latched request.
  assign ram_sel_c = ~req_q.addr[29];
  assign led_sel_c = (req_q.addr == LED_ADDR);
  assign cnt_sel_c = (req_q.addr == CNT_ADDR);
  assign ram_idx_c = req_q.addr[AW-1:0];

  // The access edge is the last BUSY edge; a reset on that edge discards it.
  assign access_c = (state_q == S_BUSY) && (wait_q == '0);
  assign ram_we_c = access_c && reset && req_q.is_wr && ram_sel_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    mem_ready_d = 1'b0;
    led_d       = led_q;

    case (state_q)
      S_IDLE: begin
        if (bus.re || (bus.we != 4'b0000)) begin
          req_d.addr  = bus.addr;
          req_d.we    = bus.we;
          req_d.wdata = bus.wdata;
          // A write wins when re and we are both asserted.
          req_d.is_wr = (bus.we != 4'b0000);
          wait_d      = WCW'(WAIT_STATES);
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WCW'(1);
        end else begin
          state_d     = S_RESP;
          mem_ready_d = 1'b1;
          if (req_q.is_wr) begin
            rdata_d = '0;
            if (led_sel_c && req_q.we[0]) begin
              led_d = req_q.wdata[7:0];
            end
          end else if (ram_sel_c) begin
            rdata_d = mem[ram_idx_c];
          end else if (led_sel_c) begin
            rdata_d = {24'b0, led_q};
          end else if (cnt_sel_c) begin
            rdata_d = cnt_val_c;
          end else begin
            rdata_d = '0;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
      led_q       <= led_d;
    end
  end

  // RAM byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_q.we[i]) begin
          mem[ram_idx_c][8*i +: 8] <= req_q.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign led           = led_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl. The main instance
// (WAIT_STATES=1, 16-word RAM) is driven by a request task that predicts
// rdata and completion cycle from the address map and pushes them into a
// queue; a negedge monitor pops and compares on each mem_ready pulse.
// Side instances cover WAIT_STATES=0/15 streaming and a reset mid-write.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int unsigned RW = 16;
  localparam int unsigned WS = 1;
  localparam logic [29:0] LED_A = 30'h2000_0000;
  localparam logic [29:0] CNT_A = 30'h2000_0001;
  localparam logic [29:0] NUL_A = 30'h2000_0002;

  logic clk = 1'b0;
  logic reset;
  logic reset3;
  always #5 clk = ~clk;

  mem_ctrl_if bus0();
  mem_ctrl_if bus_a();
  mem_ctrl_if bus_b();
  mem_ctrl_if bus_c();
  logic [7:0] led0, led_a, led_b, led_c;

  mem_ctrl #(.RAM_WORDS(RW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0), .led(led0));
  mem_ctrl #(.RAM_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .bus(bus_a), .led(led_a));
  mem_ctrl #(.RAM_WORDS(64), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .reset(reset), .bus(bus_b), .led(led_b));
  mem_ctrl #(.RAM_WORDS(RW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset3), .bus(bus_c), .led(led_c));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Posedge count since time 0, and index of the last edge that saw reset low.
  int unsigned cyc_n = 0;
  int unsigned rst_edge = 0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!reset) rst_edge <= cyc_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state and scoreboard.
  typedef struct {
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] ram_m [RW];
  logic [7:0]  led_m = 8'h00;
  logic        prev_rdy0 = 1'b0;

  // Monitor: compare every completion against the head of the scoreboard.
  always @(negedge clk) begin
    if (bus0.mem_ready === 1'b1) begin
      check("rdy_width", {31'b0, prev_rdy0}, 32'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_ready: mem_ready with no request outstanding (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdata", bus0.rdata, mon_e.rdata);
        check("latency", cyc_n, mon_e.due);
      end
    end
    prev_rdy0 = (bus0.mem_ready === 1'b1);
  end

  // Issue one request to the main instance from an IDLE-cycle negedge,
  // predict its result, hold it until mem_ready, then release it.
  task automatic issue(input logic [29:0] a, input logic r, input logic [3:0] w,
                       input logic [31:0] d, output logic [31:0] got);
    exp_t        e;
    int unsigned idx;
    bit          seen;
    idx   = a % RW;
    e.due = cyc_n + 2 + WS;
    if (w != 4'b0000) begin
      e.rdata = 32'd0;
      if (!a[29]) begin
        for (int i = 0; i < 4; i++) begin
          if (w[i]) ram_m[idx][8*i +: 8] = d[8*i +: 8];
        end
      end else if (a == LED_A && w[0]) begin
        led_m = d[7:0];
      end
    end else begin
      if (!a[29]) begin
        e.rdata = ram_m[idx];
      end else if (a == LED_A) begin
        e.rdata = {24'b0, led_m};
      end else if (a == CNT_A) begin
`ifdef MEM_CTRL_TIMER_EN
        e.rdata = 32'(cyc_n + WS + 1 - rst_edge);
`else
        e.rdata = 32'd0;
`endif
      end else begin
        e.rdata = 32'd0;
      end
    end
    sb_q.push_back(e);
    bus0.addr  = a;
    bus0.re    = r;
    bus0.we    = w;
    bus0.wdata = d;
    seen = 1'b0;
    got  = 32'hxxxx_xxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus0.mem_ready === 1'b1) begin
        seen = 1'b1;
        got  = bus0.rdata;
        break;
      end
    end
    bus0.re = 1'b0;
    bus0.we = 4'b0000;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no mem_ready for addr %h within 40 cycles", a);
      sb_q.delete();
    end else begin
      check("led", {24'b0, led0}, {24'b0, led_m});
    end
    @(negedge clk);
  endtask

  // Wait for a completion on the WAIT_STATES=3 instance and check its cycle.
  task automatic wait_c(input string name, input int unsigned due);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_c.mem_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen ? cyc_n : 32'hFFFF_FFFF, due);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] got, t1, t2;
  logic [29:0] ra;
  logic [3:0]  rw;
  logic        rr;
  int unsigned sel, n1;

  initial begin
    reset  = 1'b0;
    reset3 = 1'b0;
    bus0.addr = '0;  bus0.re = 1'b0;  bus0.we = '0;  bus0.wdata = '0;
    bus_a.addr = '0; bus_a.re = 1'b0; bus_a.we = '0; bus_a.wdata = '0;
    bus_b.addr = '0; bus_b.re = 1'b0; bus_b.we = '0; bus_b.wdata = '0;
    bus_c.addr = '0; bus_c.re = 1'b0; bus_c.we = '0; bus_c.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus0.mem_ready}, 32'd0);
    check("rst_rdata", bus0.rdata, 32'd0);
    check("rst_led", {24'b0, led0}, 32'd0);
    reset  = 1'b1;
    reset3 = 1'b1;

    fork
      // Main instance: directed cases, then randomized traffic.
      begin
        for (int i = 0; i < RW; i++) issue(30'(i), 1'b0, 4'hF, $urandom, got);
        issue(30'd5, 1'b0, 4'hF, 32'hDEAD_BEEF, got);
        issue(30'd5, 1'b1, 4'h0, 32'h0, got);
        check("rd_deadbeef", got, 32'hDEAD_BEEF);
        issue(30'd5, 1'b0, 4'b0101, 32'h1122_3344, got);
        issue(30'd5, 1'b1, 4'h0, 32'h0, got);
        check("byte_lanes", got, 32'hDE22_BE44);
        issue(LED_A, 1'b0, 4'h1, 32'h0000_01A5, got);
        check("led_write", {24'b0, led0}, 32'h0000_00A5);
        issue(LED_A, 1'b1, 4'h0, 32'h0, got);
        check("led_read", got, 32'h0000_00A5);
        issue(NUL_A, 1'b1, 4'h0, 32'h0, got);
        check("mmio_hole", got, 32'd0);
        issue(LED_A, 1'b0, 4'b0010, 32'h0000_3C00, got);
        issue(30'd5, 1'b1, 4'hF, 32'hCAFE_F00D, got);
        check("re_we_write", got, 32'd0);
        issue(30'd5 | 30'h0000_0400, 1'b1, 4'h0, 32'h0, got);
        issue(CNT_A, 1'b0, 4'hF, 32'h1234_5678, got);
        n1 = cyc_n;
        issue(CNT_A, 1'b1, 4'h0, 32'h0, t1);
        while (cyc_n < n1 + 10) @(negedge clk);
        issue(CNT_A, 1'b1, 4'h0, 32'h0, t2);
`ifdef MEM_CTRL_TIMER_EN
        check("timer_delta", t2 - t1, 32'd10);
`else
        check("timer_off_1", t1, 32'd0);
        check("timer_off_2", t2, 32'd0);
`endif
        for (int k = 0; k < 300; k++) begin
          sel = $urandom_range(0, 9);
          if (sel < 6)       ra = {1'b0, 29'($urandom)};
          else if (sel == 6) ra = LED_A;
          else if (sel == 7) ra = CNT_A;
          else               ra = {1'b1, 29'($urandom)};
          rw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          rr = 1'($urandom);
          if (rw == 4'h0) rr = 1'b1;
          issue(ra, rr, rw, $urandom, got);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end

      // Streaming reads with re held high on WAIT_STATES=0 and 15.
      begin
        int unsigned n0, last_a, last_b, pa, pb;
        bit prev_a, prev_b;
        bus_a.addr = NUL_A; bus_a.re = 1'b1;
        bus_b.addr = NUL_A; bus_b.re = 1'b1;
        n0 = cyc_n; last_a = n0; last_b = n0; pa = 0; pb = 0;
        prev_a = 1'b0; prev_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (bus_a.mem_ready === 1'b1) begin
            check("ws0_period", cyc_n - last_a, (pa == 0) ? 32'd2 : 32'd3);
            check("ws0_width", {31'b0, prev_a}, 32'd0);
            check("ws0_rdata", bus_a.rdata, 32'd0);
            last_a = cyc_n; pa++;
          end
          if (bus_b.mem_ready === 1'b1) begin
            check("ws15_period", cyc_n - last_b, (pb == 0) ? 32'd17 : 32'd18);
            check("ws15_width", {31'b0, prev_b}, 32'd0);
            last_b = cyc_n; pb++;
          end
          prev_a = (bus_a.mem_ready === 1'b1);
          prev_b = (bus_b.mem_ready === 1'b1);
        end
        bus_a.re = 1'b0;
        bus_b.re = 1'b0;
        check("ws0_pulses", pa, 32'd33);
        check("ws15_pulses", pb, 32'd5);
      end

      // Reset during the first BUSY cycle of a write, WAIT_STATES=3.
      begin
        int unsigned nc, hits;
        nc = cyc_n;
        bus_c.addr = 30'd7; bus_c.we = 4'hF; bus_c.wdata = 32'h0;
        wait_c("ws3_seed_lat", nc + 5);
        bus_c.we = 4'h0;
        @(negedge clk);
        bus_c.wdata = 32'h5555_5555; bus_c.we = 4'hF;
        @(negedge clk);
        reset3 = 1'b0;
        @(negedge clk);
        reset3 = 1'b1;
        bus_c.we = 4'h0;
        hits = 0;
        for (int k = 0; k < 25; k++) begin
          @(negedge clk);
          if (bus_c.mem_ready === 1'b1) hits++;
        end
        check("ws3_no_ready", hits, 32'd0);
        check("ws3_led", {24'b0, led_c}, 32'd0);
        nc = cyc_n;
        bus_c.re = 1'b1;
        wait_c("ws3_rd_lat", nc + 5);
        check("ws3_rd_addr7", bus_c.rdata, 32'd0);
        bus_c.re = 1'b0;
      end
    join

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
